// File: rtl/rotate_ctrl.sv
// Rotation-angle controller: tracks a target angle from key pulses and auto-rotate
// ticks, and commits it to the datapath once per frame through a req/ack handshake.
module rotate_ctrl #(
  parameter int unsigned ANG_W       = 9,
  parameter int unsigned STEP        = 15,
  parameter int unsigned AUTO_STEP   = 1,
  parameter int unsigned AUTO_FRAMES = 4,
  parameter int unsigned ACK_TMO     = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       key_in,
  input  logic             frame_start,
  input  logic             cfg_ack,
  output logic             cfg_req,
  output logic [ANG_W-1:0] cfg_angle,
  output logic [ANG_W-1:0] angle,
  output logic             auto_mode,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             busy
);

  // One extra bit so that the sum of two in-range angles never overflows.
  localparam int unsigned SumW = ANG_W + 1;
  localparam int unsigned AcW  = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam int unsigned TmoW = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;

  localparam logic [SumW-1:0] FullTurn = SumW'(360);
  localparam logic [SumW-1:0] StepUp   = SumW'(STEP);
  localparam logic [SumW-1:0] StepDn   = SumW'(360 - STEP);
  localparam logic [SumW-1:0] AutoInc  = SumW'(AUTO_STEP);
  localparam logic [AcW-1:0]  AutoLast = AcW'(AUTO_FRAMES - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(ACK_TMO - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PEND = 2'd1;
  localparam logic [1:0] REQ  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ANG_W-1:0] target_q, target_d;
  logic [ANG_W-1:0] angle_q, angle_d;
  logic [ANG_W-1:0] cfg_angle_q, cfg_angle_d;
  logic             auto_mode_q, auto_mode_d;
  logic [AcW-1:0]   auto_cnt_q, auto_cnt_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic             cfg_done_q, cfg_done_d;
  logic             cfg_err_q, cfg_err_d;

  logic [SumW-1:0]  manual_delta;
  logic [SumW-1:0]  auto_inc;
  logic [SumW-1:0]  sum_man_raw, sum_man;
  logic [SumW-1:0]  sum_tot_raw, sum_tot;

  // Manual step: opposing keys in the same cycle cancel out.
  always_comb begin
    manual_delta = '0;
    if (key_in[0] && !key_in[1]) begin
      manual_delta = StepUp;
    end else if (key_in[1] && !key_in[0]) begin
      manual_delta = StepDn;
    end
  end

  // Auto-mode toggle and frame divider; a toggle clears the divider and wins over a tick.
  always_comb begin
    auto_mode_d = auto_mode_q;
    auto_cnt_d  = auto_cnt_q;
    auto_inc    = '0;
    if (key_in[2]) begin
      auto_mode_d = ~auto_mode_q;
      auto_cnt_d  = '0;
    end else if (auto_mode_q && frame_start) begin
      if (auto_cnt_q == AutoLast) begin
        auto_cnt_d = '0;
        auto_inc   = AutoInc;
      end else begin
        auto_cnt_d = auto_cnt_q + 1'b1;
      end
    end
  end

  // Target update: each addend is below 360, so one conditional subtract per stage suffices.
  always_comb begin
    sum_man_raw = {1'b0, target_q} + manual_delta;
    sum_man     = (sum_man_raw >= FullTurn) ? (sum_man_raw - FullTurn) : sum_man_raw;
    sum_tot_raw = sum_man + auto_inc;
    sum_tot     = (sum_tot_raw >= FullTurn) ? (sum_tot_raw - FullTurn) : sum_tot_raw;
    target_d    = sum_tot[ANG_W-1:0];
  end

  // Commit FSM: wait for a frame boundary, snapshot target, hold request until ack or timeout.
  always_comb begin
    state_d     = state_q;
    angle_d     = angle_q;
    cfg_angle_d = cfg_angle_q;
    tmo_cnt_d   = tmo_cnt_q;
    cfg_done_d  = 1'b0;
    cfg_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (target_q != angle_q) begin
          state_d = PEND;
        end
      end
      PEND: begin
        // Target drifting back to the committed angle cancels the pending commit.
        if (target_q == angle_q) begin
          state_d = IDLE;
        end else if (frame_start) begin
          state_d     = REQ;
          cfg_angle_d = target_q;
          tmo_cnt_d   = '0;
        end
      end
      REQ: begin
        if (cfg_ack) begin
          angle_d    = cfg_angle_q;
          cfg_done_d = 1'b1;
          state_d    = IDLE;
        end else if (tmo_cnt_q == TmoLast) begin
          cfg_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      target_q    <= '0;
      angle_q     <= '0;
      cfg_angle_q <= '0;
      auto_mode_q <= 1'b0;
      auto_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      angle_q     <= angle_d;
      cfg_angle_q <= cfg_angle_d;
      auto_mode_q <= auto_mode_d;
      auto_cnt_q  <= auto_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cfg_done_q  <= cfg_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Request and busy are decoded straight from state, so reset drops them immediately.
  always_comb begin
    cfg_req   = (state_q == REQ);
    busy      = (state_q != IDLE);
    cfg_angle = cfg_angle_q;
    angle     = angle_q;
    auto_mode = auto_mode_q;
    cfg_done  = cfg_done_q;
    cfg_err   = cfg_err_q;
  end

endmodule

// File: tb/tb_rotate_ctrl.sv
// Bench for rotate_ctrl: a hand-computed vector table, directed multi-cycle sequences,
// and randomized stimulus against an arithmetic reference model.
module tb_rotate_ctrl;

  localparam int ANG_W       = 9;
  localparam int STEP        = 15;
  localparam int AUTO_STEP   = 1;
  localparam int AUTO_FRAMES = 4;
  localparam int ACK_TMO     = 1024;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       key_in = '0;
  logic             frame_start = 1'b0;
  logic             cfg_ack = 1'b0;
  logic             cfg_req;
  logic [ANG_W-1:0] cfg_angle;
  logic [ANG_W-1:0] angle;
  logic             auto_mode;
  logic             cfg_done;
  logic             cfg_err;
  logic             busy;

  rotate_ctrl #(
    .ANG_W      (ANG_W),
    .STEP       (STEP),
    .AUTO_STEP  (AUTO_STEP),
    .AUTO_FRAMES(AUTO_FRAMES),
    .ACK_TMO    (ACK_TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .frame_start(frame_start),
    .cfg_ack    (cfg_ack),
    .cfg_req    (cfg_req),
    .cfg_angle  (cfg_angle),
    .angle      (angle),
    .auto_mode  (auto_mode),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: angles as plain integers, phase 0=idle, 1=waiting for frame, 2=requesting.
  int m_target, m_angle, m_snap, m_phase, m_age, m_cnt;
  bit m_auto, m_done, m_err;

  task automatic model_reset();
    m_target = 0; m_angle = 0; m_snap = 0; m_phase = 0; m_age = 0; m_cnt = 0;
    m_auto = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [2:0] k, input logic f, input logic a);
    int delta, adv, old_t;
    old_t = m_target;
    delta = 0;
    adv   = 0;
    if (k[0] && !k[1]) delta = STEP;
    else if (k[1] && !k[0]) delta = -STEP;
    if (k[2]) begin
      m_auto = !m_auto;
      m_cnt  = 0;
    end else if (m_auto && f) begin
      m_cnt++;
      if (m_cnt == AUTO_FRAMES) begin
        m_cnt = 0;
        adv   = AUTO_STEP;
      end
    end
    m_target = ((old_t + delta + adv) % 360 + 360) % 360;
    m_done = 0;
    m_err  = 0;
    case (m_phase)
      0: if (old_t != m_angle) m_phase = 1;
      1: begin
        if (old_t == m_angle) m_phase = 0;
        else if (f) begin
          m_phase = 2;
          m_snap  = old_t;
          m_age   = 0;
        end
      end
      default: begin
        m_age++;
        if (a) begin
          m_angle = m_snap;
          m_done  = 1;
          m_phase = 0;
        end else if (m_age == ACK_TMO) begin
          m_err   = 1;
          m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic check_model();
    check("req", 32'(cfg_req), 32'(m_phase == 2));
    check("angle", 32'(angle), 32'(m_angle));
    check("done", 32'(cfg_done), 32'(m_done));
    check("err", 32'(cfg_err), 32'(m_err));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("auto", 32'(auto_mode), 32'(m_auto));
    if (m_phase == 2) check("cfg_angle", 32'(cfg_angle), 32'(m_snap));
  endtask

  // Drive one cycle of inputs, advance past the edge, update the model.
  task automatic tick(input logic [2:0] k, input logic f, input logic a);
    key_in      = k;
    frame_start = f;
    cfg_ack     = a;
    @(posedge clk);
    model_step(k, f, a);
    #1;
    key_in      = '0;
    frame_start = 1'b0;
    cfg_ack     = 1'b0;
  endtask

  task automatic tick_chk(input logic [2:0] k, input logic f, input logic a);
    tick(k, f, a);
    check_model();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [2:0] key;
    logic       f;
    logic       a;
    logic       req;
    int         ang;
    int         cfga;
    logic       done;
    logic       err;
    logic       bsy;
  } vec_t;

  vec_t tbl[18];

  int  n_high;
  bit  err_seen;
  bit  ack_never;
  logic [2:0] rk;
  logic rf, ra;

  initial begin
    tbl[0]  = '{3'd1, 1'b0, 1'b0, 1'b0,   0,   0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{3'd0, 1'b0, 1'b0, 1'b0,   0,   0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{3'd0, 1'b1, 1'b0, 1'b1,   0,  15, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{3'd0, 1'b0, 1'b0, 1'b1,   0,  15, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{3'd0, 1'b0, 1'b0, 1'b1,   0,  15, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{3'd0, 1'b0, 1'b1, 1'b0,  15,   0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{3'd0, 1'b0, 1'b0, 1'b0,  15,   0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{3'd3, 1'b0, 1'b0, 1'b0,  15,   0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{3'd0, 1'b0, 1'b0, 1'b0,  15,   0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3'd2, 1'b0, 1'b0, 1'b0,  15,   0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{3'd2, 1'b0, 1'b0, 1'b0,  15,   0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{3'd0, 1'b1, 1'b0, 1'b1,  15, 345, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{3'd0, 1'b0, 1'b1, 1'b0, 345,   0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{3'd0, 1'b0, 1'b0, 1'b0, 345,   0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{3'd1, 1'b0, 1'b0, 1'b0, 345,   0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{3'd2, 1'b0, 1'b0, 1'b0, 345,   0, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{3'd0, 1'b0, 1'b0, 1'b0, 345,   0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{3'd0, 1'b0, 1'b0, 1'b0, 345,   0, 1'b0, 1'b0, 1'b0};

    model_reset();
    @(posedge clk);
    #1;
    check("rst_req", 32'(cfg_req), 0);
    check("rst_angle", 32'(angle), 0);
    check("rst_cfg_angle", 32'(cfg_angle), 0);
    check("rst_auto", 32'(auto_mode), 0);
    check("rst_flags", {29'd0, cfg_done, cfg_err, busy}, 0);
    rst_n = 1'b1;

    // Commit of one CW step, cancelled CW+CCW, wrap-down commit, and a cancelled pending.
    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].key, tbl[i].f, tbl[i].a);
      check($sformatf("tbl%0d_req", i), 32'(cfg_req), 32'(tbl[i].req));
      check($sformatf("tbl%0d_angle", i), 32'(angle), 32'(tbl[i].ang));
      check($sformatf("tbl%0d_done", i), 32'(cfg_done), 32'(tbl[i].done));
      check($sformatf("tbl%0d_err", i), 32'(cfg_err), 32'(tbl[i].err));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      if (tbl[i].req) check($sformatf("tbl%0d_cfga", i), 32'(cfg_angle), 32'(tbl[i].cfga));
    end

    // Wrap-up: 23 CW steps reach 345, the 24th lands back on 0.
    do_reset();
    for (int i = 0; i < 23; i++) tick_chk(3'd1, 1'b0, 1'b0);
    tick_chk(3'd0, 1'b0, 1'b0);
    tick_chk(3'd0, 1'b1, 1'b0);
    tick_chk(3'd0, 1'b0, 1'b1);
    check("wrap_345", 32'(angle), 345);
    tick_chk(3'd1, 1'b0, 1'b0);
    tick_chk(3'd0, 1'b0, 1'b0);
    tick_chk(3'd0, 1'b1, 1'b0);
    tick_chk(3'd0, 1'b0, 1'b1);
    check("wrap_0", 32'(angle), 0);

    // Keys during REQ move only the target; a second commit follows.
    do_reset();
    tick_chk(3'd1, 1'b0, 1'b0);
    tick_chk(3'd0, 1'b0, 1'b0);
    tick_chk(3'd0, 1'b1, 1'b0);
    tick_chk(3'd1, 1'b0, 1'b0);
    tick_chk(3'd1, 1'b1, 1'b0);
    check("req_frozen", 32'(cfg_angle), 15);
    tick_chk(3'd0, 1'b0, 1'b1);
    check("req4_angle", 32'(angle), 15);
    check("req4_done", 32'(cfg_done), 1);
    tick_chk(3'd0, 1'b0, 1'b0);
    check("req4_pend", 32'(busy), 1);
    tick_chk(3'd0, 1'b1, 1'b0);
    check("req4_cfga", 32'(cfg_angle), 45);
    tick_chk(3'd0, 1'b0, 1'b1);
    check("req4_angle2", 32'(angle), 45);

    // Timeout: request held exactly ACK_TMO cycles, then error and retry.
    do_reset();
    tick_chk(3'd1, 1'b0, 1'b0);
    tick_chk(3'd0, 1'b0, 1'b0);
    tick_chk(3'd0, 1'b1, 1'b0);
    n_high   = 0;
    err_seen = 0;
    for (int i = 0; i < ACK_TMO + 20; i++) begin
      if (!cfg_req) break;
      n_high++;
      tick_chk(3'd0, 1'b0, 1'b0);
      if (cfg_err) err_seen = 1;
    end
    check("tmo_len", 32'(n_high), 32'(ACK_TMO));
    check("tmo_err", 32'(err_seen), 1);
    check("tmo_angle", 32'(angle), 0);
    tick_chk(3'd0, 1'b0, 1'b0);
    tick_chk(3'd0, 1'b1, 1'b0);
    check("retry_req", 32'(cfg_req), 1);
    check("retry_cfga", 32'(cfg_angle), 15);
    tick_chk(3'd0, 1'b0, 1'b1);

    // Auto-rotate: one degree per four frames, commits at the following frame.
    do_reset();
    tick_chk(3'd4, 1'b0, 1'b0);
    check("auto_on", 32'(auto_mode), 1);
    for (int i = 0; i < 8; i++) begin
      tick_chk(3'd0, 1'b1, 1'b0);
      if (cfg_req) tick_chk(3'd0, 1'b0, 1'b1);
      tick_chk(3'd0, 1'b0, 1'b0);
      tick_chk(3'd0, 1'b0, 1'b0);
    end
    check("auto_angle1", 32'(angle), 1);
    tick_chk(3'd4, 1'b0, 1'b0);
    check("auto_off", 32'(auto_mode), 0);
    for (int i = 0; i < 8; i++) begin
      tick_chk(3'd0, 1'b1, 1'b0);
      if (cfg_req) tick_chk(3'd0, 1'b0, 1'b1);
      tick_chk(3'd0, 1'b0, 1'b0);
    end
    check("auto_angle2", 32'(angle), 2);
    check("auto_idle", 32'(busy), 0);

    // Asynchronous reset while the request is up.
    tick_chk(3'd1, 1'b0, 1'b0);
    tick_chk(3'd0, 1'b0, 1'b0);
    tick_chk(3'd0, 1'b1, 1'b0);
    check("pre_rst_req", 32'(cfg_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(cfg_req), 0);
    check("arst_angle", 32'(angle), 0);
    check("arst_cfga", 32'(cfg_angle), 0);
    check("arst_auto", 32'(auto_mode), 0);
    check("arst_flags", {29'd0, cfg_done, cfg_err, busy}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Random stimulus, with a long no-ack window in the middle to force timeouts.
    for (int c = 0; c < 3600; c++) begin
      int r;
      ack_never = (c >= 1200 && c < 2600);
      r = int'($urandom_range(0, 99));
      if (r < 6) rk = 3'd1;
      else if (r < 12) rk = 3'd2;
      else if (r < 14) rk = 3'd3;
      else if (r < 15) rk = 3'd4;
      else if (r < 17) rk = 3'($urandom_range(0, 7));
      else rk = 3'd0;
      rf = ($urandom_range(0, 19) == 0);
      ra = !ack_never && ($urandom_range(0, 3) == 0);
      tick_chk(rk, rf, ra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
